seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SCAN_LOG2, default 17, log2 of clk cycles per digit slot, legal range 5..24.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period, legal range 1..255.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port digits  in  4*NUM_DIGITS  hex nibbles, digit k at bits [4k+3:4k].
REQ-007 SHALL have port dp  in  NUM_DIGITS  decimal-point request per digit, 1=lit.
REQ-008 SHALL have port blank  in  NUM_DIGITS  per-digit blank mask, 1=dark.
REQ-009 SHALL have port blink  in  NUM_DIGITS  per-digit blink enable.
REQ-010 SHALL have port brightness  in  4  global duty level, 0=off, 15=max.
REQ-011 SHALL have port seg_n  out  7  segments a..g at bits 0..6, active-low.
REQ-012 SHALL have port dp_n  out  1  decimal point, active-low.
REQ-013 SHALL have port an  out  NUM_DIGITS  digit anodes, active-low, at most one bit low.
REQ-014 SHALL have port frame_start  out  1  one-clk pulse per scan frame.

Function
REQ-015 SHALL run slot_cnt (SCAN_LOG2 bits), incrementing every clk and wrapping 2^SCAN_LOG2-1 -> 0.
REQ-016 SHALL advance digit index idx on slot_cnt wrap: 0,1..NUM_DIGITS-1, then 0; non-power-of-2 counts are never skipped or extended.
REQ-017 SHALL define phase = slot_cnt[SCAN_LOG2-1:SCAN_LOG2-4], 16 phases per slot.
REQ-018 SHALL snapshot digits, dp, blank, blink and brightness on every clk edge where idx=0 and slot_cnt=0, and drive outputs only from the snapshot (no tearing mid-frame).
REQ-019 SHALL hold blink_phase, toggling after each BLINK_FRAMES completed frames; the frame counter wraps at BLINK_FRAMES-1.
REQ-020 SHALL treat digit idx as lit when: 1 <= phase <= snap_brightness, snap_blank[idx]=0, and NOT (snap_blink[idx]=1 AND blink_phase=1).
REQ-021 SHALL make phase 0 of every slot dead time: all an high, giving ghost suppression across digit changes.
REQ-022 SHALL, when lit, drive an[idx]=0 with all other bits 1, seg_n = ~hex7(snap nibble idx), and dp_n = ~snap_dp[idx]; when not lit, an, seg_n and dp_n are all ones.
REQ-023 SHALL decode hex 0-F to standard shapes (A,b,C,d,E,F for 10-15).
REQ-024 SHALL register all outputs: they reflect counter state with exactly 1 clk latency.
REQ-025 SHALL assert frame_start for exactly one clk, in the cycle after each snapshot edge.
REQ-026 SHALL give brightness=0 a fully dark display and brightness=15 a duty of 15/16 per slot.
REQ-027 SHALL let input changes between snapshots have no effect until the next frame.

Reset
REQ-028 SHALL, while reset_n=0, force an, seg_n and dp_n to all ones and frame_start to 0.
REQ-029 SHALL, while reset_n=0, clear slot_cnt, idx, blink frame counter, blink_phase and snapshot to 0.
REQ-030 SHALL make the first snapshot on the first clk edge after reset_n rises; reset mid-frame aborts the frame with no partial-output glitch.

Structure
REQ-031 SHALL place the 16-entry hex-to-segment table constant and the segment bit-order constants in the shared display package.
REQ-032 SHALL instantiate one combinational sub-module hex7seg (4-bit in, 7-bit active-high segments out).

Verification
(NUM_DIGITS=4, SCAN_LOG2=5, BLINK_FRAMES=2: 32-clk slots, 2-clk phases, 128-clk frames)
REQ-033 SHALL cover: reset_n low mid-frame -> an=4'hF, seg_n=7'h7F and dp_n=1 immediately; frame_start pulses 1 clk after release.
REQ-034 SHALL cover: digits=16'h1234, brightness=15 -> slot 0 has an=4'b1110 and seg_n=~hex7(4) for clk 3..32 (dark clk 1..2); then slot 1 shows 3, slot 2 shows 2, slot 3 shows 1.
REQ-035 SHALL cover: brightness=4 -> each slot has an active for exactly 8 clk, phases 1..4; brightness=0 -> an stays 4'hF for a full frame.
REQ-036 SHALL cover: digits changed at clk 50 of a frame -> old values persist until the next frame_start, then switch.
REQ-037 SHALL cover: blink=4'b0001, blank=4'b0100 -> digit 2 never lit; digit 0 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5.
REQ-038 SHALL cover: NUM_DIGITS=3 -> idx sequence 0,1,2,0; frame_start every 96 clk; dp=3'b010 -> dp_n=0 only during digit 1 lit phases.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// Shared display constants: segment bit order and the hex-to-segment shape table.
package seg_scan_mux_pkg;

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned PHASE_W = 4;

   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   // Active-high segments, bit SEG_A..SEG_G; entry 15 first, entry 0 last.
   localparam logic [15:0][SEG_W-1:0] HEX7_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high seven-segment decoder.
module hex7seg
   import seg_scan_mux_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] segs_c
);

   assign segs_c = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with per-frame input snapshot, PWM brightness and blink.
module seg_scan_mux
   import seg_scan_mux_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_LOG2    = 17,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic [3:0]              brightness,
   output logic [SEG_W-1:0]        seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned FC_W  = $clog2(BLINK_FRAMES + 1);

   logic [SCAN_LOG2-1:0]    slot_cnt, slot_next;
   logic [IDX_W-1:0]        idx, idx_next;
   logic [FC_W-1:0]         frame_cnt, fcnt_next;
   logic                    blink_phase, bph_next;

   logic [4*NUM_DIGITS-1:0] snap_digits;
   logic [NUM_DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
   logic [3:0]              snap_brightness;

   logic                    snap_edge, slot_wrap, last_digit, lit;
   logic [PHASE_W-1:0]      phase;
   logic [NIB_W-1:0]        nibble;
   logic [SEG_W-1:0]        segs_c;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [SEG_W-1:0]        seg_next;
   logic                    dp_next;

   assign slot_wrap  = (slot_cnt == '1);
   assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
   assign snap_edge  = (slot_cnt == '0) && (idx == '0);
   assign phase      = slot_cnt[SCAN_LOG2-1 -: PHASE_W];
   assign nibble     = NIB_W'(snap_digits >> {idx, 2'b00});

   hex7seg u_hex7seg (
      .nibble (nibble),
      .segs_c (segs_c)
   );

   // Scan position and blink timing
   always_comb begin
      slot_next = slot_cnt + SCAN_LOG2'(1);
      idx_next  = idx;
      fcnt_next = frame_cnt;
      bph_next  = blink_phase;
      if (slot_wrap) begin
         if (last_digit) begin
            idx_next = '0;
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
               fcnt_next = '0;
               bph_next  = ~blink_phase;
            end else begin
               fcnt_next = frame_cnt + FC_W'(1);
            end
         end else begin
            idx_next = idx + IDX_W'(1);
         end
      end
   end

   // Phase 0 is dead time so the anode never overlaps a digit change
   always_comb begin
      lit      = 1'b0;
      an_next  = '1;
      seg_next = '1;
      dp_next  = 1'b1;
      if ((phase != '0) && (phase <= snap_brightness) && !snap_blank[idx] &&
          !(snap_blink[idx] && blink_phase)) begin
         lit = 1'b1;
      end
      if (lit) begin
         an_next  = ~(NUM_DIGITS'(1) << idx);
         seg_next = ~segs_c;
         dp_next  = ~snap_dp[idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_cnt        <= '0;
         idx             <= '0;
         frame_cnt       <= '0;
         blink_phase     <= 1'b0;
         snap_digits     <= '0;
         snap_dp         <= '0;
         snap_blank      <= '0;
         snap_blink      <= '0;
         snap_brightness <= '0;
         an              <= '1;
         seg_n           <= '1;
         dp_n            <= 1'b1;
         frame_start     <= 1'b0;
      end else begin
         slot_cnt    <= slot_next;
         idx         <= idx_next;
         frame_cnt   <= fcnt_next;
         blink_phase <= bph_next;
         if (snap_edge) begin
            snap_digits     <= digits;
            snap_dp         <= dp;
            snap_blank      <= blank;
            snap_blink      <= blink;
            snap_brightness <= brightness;
         end
         an          <= an_next;
         seg_n       <= seg_next;
         dp_n        <= dp_next;
         frame_start <= snap_edge;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboarded bench for seg_scan_mux: 4-digit and 3-digit instances, 32-clk slots, 2-frame blink.
module tb_seg_scan_mux;
   import seg_scan_mux_pkg::*;

   logic        clk, rst_n;
   logic [15:0] dig4;
   logic [3:0]  dp4, blank4, blink4, br4, an4;
   logic [6:0]  segn4;
   logic        dpn4, fs4;
   logic [11:0] dig3;
   logic [2:0]  dp3, blank3, blink3, an3;
   logic [3:0]  br3;
   logic [6:0]  segn3;
   logic        dpn3, fs3;

   int total = 0;
   int bad   = 0;

   seg_scan_mux #(.NUM_DIGITS(4), .SCAN_LOG2(5), .BLINK_FRAMES(2)) dut4 (
      .clk(clk), .reset_n(rst_n), .digits(dig4), .dp(dp4), .blank(blank4), .blink(blink4),
      .brightness(br4), .seg_n(segn4), .dp_n(dpn4), .an(an4), .frame_start(fs4));

   seg_scan_mux #(.NUM_DIGITS(3), .SCAN_LOG2(5), .BLINK_FRAMES(2)) dut3 (
      .clk(clk), .reset_n(rst_n), .digits(dig3), .dp(dp3), .blank(blank3), .blink(blink3),
      .brightness(br3), .seg_n(segn3), .dp_n(dpn3), .an(an3), .frame_start(fs3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] sm(int unsigned b);
      return 7'(1 << b);
   endfunction

   // Segment shapes built letter by letter
   function automatic logic [6:0] shape(logic [3:0] h);
      logic [6:0] a = sm(SEG_A), b = sm(SEG_B), c = sm(SEG_C), d = sm(SEG_D);
      logic [6:0] e = sm(SEG_E), f = sm(SEG_F), g = sm(SEG_G);
      case (h)
         4'h0: return a | b | c | d | e | f;
         4'h1: return b | c;
         4'h2: return a | b | g | e | d;
         4'h3: return a | b | g | c | d;
         4'h4: return f | g | b | c;
         4'h5: return a | f | g | c | d;
         4'h6: return a | f | g | e | d | c;
         4'h7: return a | b | c;
         4'h8: return a | b | c | d | e | f | g;
         4'h9: return a | b | c | d | f | g;
         4'hA: return a | b | c | e | f | g;
         4'hB: return c | d | e | f | g;
         4'hC: return a | d | e | f;
         4'hD: return b | c | d | e | g;
         4'hE: return a | d | e | f | g;
         default: return a | e | f | g;
      endcase
   endfunction

   function automatic logic [6:0] nseg(logic [3:0] h);
      return ~shape(h);
   endfunction

   // Expected {frame_start, dp_n, seg_n, an padded to 8} for the k-th edge after release
   function automatic logic [16:0] model(int unsigned n, int unsigned k, logic [31:0] sd,
                                         logic [7:0] sdp, logic [7:0] sbl, logic [7:0] sbk,
                                         logic [3:0] sbr);
      int unsigned slot  = k % 32;
      int unsigned idx   = (k / 32) % n;
      int unsigned frame = k / (32 * n);
      int unsigned ph    = slot / 2;
      bit          bph   = ((frame / 2) % 2) == 1;
      bit          on    = (ph >= 1) && (ph <= 32'(sbr)) && !sbl[idx] && !(sbk[idx] && bph);
      logic [7:0]  an    = 8'hFF;
      logic [6:0]  seg   = 7'h7F;
      logic        dpn   = 1'b1;
      if (on) begin
         an  = ~(8'(1) << idx);
         seg = nseg(4'(sd >> (4 * idx)));
         dpn = ~sdp[idx];
      end
      return {(slot == 0) && (idx == 0), dpn, seg, an};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [16:0] q4[$];
   logic [16:0] q3[$];
   int unsigned k4, k3;
   logic [31:0] m4_d, m3_d;
   logic [7:0]  m4_dp, m4_bl, m4_bk, m3_dp, m3_bl, m3_bk;
   logic [3:0]  m4_br, m3_br;

   localparam logic [16:0] RST_OUT = {1'b0, 1'b1, 7'h7F, 8'hFF};

   // Scoreboard producer: expected output of each edge, snapshot taken at frame boundaries
   always @(posedge clk) begin
      if (!rst_n) begin
         k4 = 0; k3 = 0;
         m4_d = '0; m4_dp = '0; m4_bl = '0; m4_bk = '0; m4_br = '0;
         m3_d = '0; m3_dp = '0; m3_bl = '0; m3_bk = '0; m3_br = '0;
         q4.delete(); q3.delete();
      end else begin
         q4.push_back(model(4, k4, m4_d, m4_dp, m4_bl, m4_bk, m4_br));
         q3.push_back(model(3, k3, m3_d, m3_dp, m3_bl, m3_bk, m3_br));
         if (k4 % 128 == 0) begin
            m4_d = 32'(dig4); m4_dp = 8'(dp4); m4_bl = 8'(blank4); m4_bk = 8'(blink4); m4_br = br4;
         end
         if (k3 % 96 == 0) begin
            m3_d = 32'(dig3); m3_dp = 8'(dp3); m3_bl = 8'(blank3); m3_bk = 8'(blink3); m3_br = br3;
         end
         k4++; k3++;
      end
   end

   // Scoreboard consumer on the falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset4", 32'({fs4, dpn4, segn4, 4'hF, an4}), 32'(RST_OUT));
         check("reset3", 32'({fs3, dpn3, segn3, 5'h1F, an3}), 32'(RST_OUT));
      end else begin
         if (q4.size() > 0) check("scan4", 32'({fs4, dpn4, segn4, 4'hF, an4}), 32'(q4.pop_front()));
         if (q3.size() > 0) check("scan3", 32'({fs3, dpn3, segn3, 5'h1F, an3}), 32'(q3.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_fs(input int which);
      int n = 0;
      logic f;
      do begin
         @(negedge clk);
         n++;
         f = (which == 4) ? fs4 : fs3;
      end while (!f && n < 1000);
      check("frame_start_wait", 32'(f), 32'd1);
   endtask

   int lit, d2, n, dpc, dpbad;
   int d0[3];
   logic [6:0] seg_d0;

   initial begin
      rst_n = 1'b1;
      dig4 = 16'h1234; dp4 = '0; blank4 = '0; blink4 = '0; br4 = 4'd15;
      dig3 = 12'h567;  dp3 = 3'b010; blank3 = '0; blink3 = '0; br3 = 4'd15;
      #1 rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("fs_after_release", 32'(fs4), 32'd1);
      check("dark_clk1", 32'(an4), 32'hF);
      @(negedge clk);
      check("dark_clk2", 32'(an4), 32'hF);
      @(negedge clk);
      check("slot0_an", 32'(an4), 32'b1110);
      check("slot0_seg", 32'(segn4), 32'(nseg(4'h4)));

      // Mid-frame change must not tear the current frame
      tick(47);
      dig4 = 16'hABCD; br4 = 4'd4;
      wait_fs(4);
      br4 = 4'd0;
      lit = 0; seg_d0 = '0;
      for (int i = 0; i < 128; i++) begin
         if (i > 0) @(negedge clk);
         if (an4 != 4'hF) lit++;
         if (an4 == 4'b1110) seg_d0 = segn4;
      end
      check("lit_br4", 32'(lit), 32'd32);
      check("frame1_digit0", 32'(seg_d0), 32'(nseg(4'hD)));
      lit = 0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         if (an4 != 4'hF) lit++;
      end
      check("lit_br0", 32'(lit), 32'd0);

      // Reset in the middle of a frame
      tick(40);
      rst_n = 1'b0;
      dig4 = 16'h1234; blink4 = 4'b0001; blank4 = 4'b0100; br4 = 4'd15;
      #1;
      check("rst_an", 32'(an4), 32'hF);
      check("rst_seg", 32'(segn4), 32'h7F);
      check("rst_dp", 32'(dpn4), 32'd1);
      check("rst_fs", 32'(fs4), 32'd0);
      tick(2);
      rst_n = 1'b1;

      wait_fs(4);
      d0[0] = 0; d0[1] = 0; d0[2] = 0; d2 = 0;
      for (int i = 0; i < 768; i++) begin
         if (i > 0) @(negedge clk);
         if (an4 == 4'b1110) d0[i / 256]++;
         if (an4[2] == 1'b0) d2++;
      end
      check("blink_f01", 32'(d0[0]), 32'd60);
      check("blink_f23", 32'(d0[1]), 32'd0);
      check("blink_f45", 32'(d0[2]), 32'd60);
      check("blank_d2", 32'(d2), 32'd0);

      wait_fs(3);
      n = 0; dpc = 0; dpbad = 0;
      do begin
         @(negedge clk);
         n++;
         if (dpn3 == 1'b0) begin
            dpc++;
            if (an3 != 3'b101) dpbad++;
         end
      end while (!fs3 && n < 300);
      check("fs3_period", 32'(n), 32'd96);
      check("dp3_count", 32'(dpc), 32'd30);
      check("dp3_digit", 32'(dpbad), 32'd0);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
